// File: rtl/fire_expand1_scheduler_if.sv
// Handshake/control bundle between the fire4/fire5 expand-1x1 scheduler and
// the shared MAC datapath / output RAM.
//   master : scheduler side (drives enables, rom_addr, strobes, status)
//   slave  : datapath/RAM side (drives start, ifm_valid, RAM acknowledges)
// Widths: ADDR_W = weight ROM address width, PIX_W = pixel index width.
interface fire_expand1_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int PIX_W  = 10
);
  logic              start;
  logic              ifm_valid;
  logic              ifm_ready;
  logic              ram_ack_4;
  logic              ram_ack_5;
  logic              fire4_expand_1_en;
  logic              fire5_expand_1_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              mac_clr;
  logic              ofm_sample;
  logic [PIX_W-1:0]  pixel_idx;
  logic              busy;
  logic              done;

  modport master (
    input  start, ifm_valid, ram_ack_4, ram_ack_5,
    output ifm_ready, fire4_expand_1_en, fire5_expand_1_en, rom_addr,
           mac_clr, ofm_sample, pixel_idx, busy, done
  );

  modport slave (
    output start, ifm_valid, ram_ack_4, ram_ack_5,
    input  ifm_ready, fire4_expand_1_en, fire5_expand_1_en, rom_addr,
           mac_clr, ofm_sample, pixel_idx, busy, done
  );
endinterface

// File: rtl/fire_expand1_scheduler.sv
// Sequencer for the shared fire4/fire5 expand-1x1 MAC array. One start runs
// fire4 then fire5: steps the weight ROM address per consumed ifm word, inserts
// a one-cycle MAC clear/bias slot at the end of each output pixel, drains the
// pipeline, then waits for the output RAM writeback acknowledge of the layer.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : control bundle (master side), all outputs registered
//
// state  | meaning
// IDLE   | waiting for start
// RUN4   | accumulating fire4 pixels (ACC beats + CLR slot per pixel)
// DRAIN4 | PIPE_LAT cycles for the last fire4 ofm word to settle
// WAIT4  | waiting for fire4 writeback acknowledge
// RUN5   | accumulating fire5 pixels
// DRAIN5 | pipeline drain after fire5
// WAIT5  | waiting for fire5 writeback acknowledge
// DONE   | one-cycle completion pulse
module fire_expand1_scheduler #(
  parameter int WOUT       = 32,
  parameter int CHIN       = 32,
  parameter int KERNEL_DIM = 1,
  parameter int PIPE_LAT   = 2
) (
  input  logic clk,
  input  logic rst,
  fire_expand1_scheduler_if.master bus
);
  localparam int N      = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int NPIX   = WOUT * WOUT;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DRN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [DRN_W-1:0]  DRN_LOAD = DRN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN4, S_DRAIN4, S_WAIT4, S_RUN5, S_DRAIN5, S_WAIT5, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              clr_q, clr_d;
  logic              ofm_q, ofm_d;
  logic              rdy_q, rdy_d;
  logic              ack4_q, ack4_d;
  logic              ack5_q, ack5_d;
  logic              en4_q, en4_d;
  logic              en5_q, en5_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pix_d   = pix_q;
    drn_d   = drn_q;
    clr_d   = 1'b0;
    rdy_d   = 1'b0;
    ofm_d   = clr_q;
    ack4_d  = ack4_q;
    ack5_d  = ack5_q;

    // Acks are captured first so that the per-layer clear below, applied on
    // entry to a RUN state, takes priority over a same-cycle acknowledge.
    if (state_q != S_IDLE) begin
      if (bus.ram_ack_4) ack4_d = 1'b1;
      if (bus.ram_ack_5) ack5_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN4;
          k_d     = '0;
          pix_d   = '0;
          rdy_d   = 1'b1;
          ack4_d  = 1'b0;
        end
      end
      S_RUN4, S_RUN5: begin
        if (clr_q) begin
          // CLR slot is ending: finish the layer or move to the next pixel.
          if (pix_q == PIX_LAST) begin
            state_d = (state_q == S_RUN4) ? S_DRAIN4 : S_DRAIN5;
            drn_d   = DRN_LOAD;
          end else begin
            pix_d = pix_q + PIX_W'(1);
            rdy_d = 1'b1;
          end
        end else if (bus.ifm_valid) begin
          if (k_q == K_LAST) begin
            k_d   = '0;
            clr_d = 1'b1;
          end else begin
            k_d   = k_q + ADDR_W'(1);
            rdy_d = 1'b1;
          end
        end else begin
          rdy_d = 1'b1;
        end
      end
      S_DRAIN4, S_DRAIN5: begin
        if (drn_q == '0) begin
          state_d = (state_q == S_DRAIN4) ? S_WAIT4 : S_WAIT5;
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      S_WAIT4: begin
        if (ack4_q || bus.ram_ack_4) begin
          state_d = S_RUN5;
          k_d     = '0;
          pix_d   = '0;
          rdy_d   = 1'b1;
          ack5_d  = 1'b0;
        end
      end
      S_WAIT5: begin
        if (ack5_q || bus.ram_ack_5) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they register
    // alongside it.
    en4_d  = (state_d == S_RUN4) || (state_d == S_DRAIN4) || (state_d == S_WAIT4);
    en5_d  = (state_d == S_RUN5) || (state_d == S_DRAIN5) || (state_d == S_WAIT5);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      pix_q   <= '0;
      drn_q   <= '0;
      clr_q   <= 1'b0;
      ofm_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ack4_q  <= 1'b0;
      ack5_q  <= 1'b0;
      en4_q   <= 1'b0;
      en5_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pix_q   <= pix_d;
      drn_q   <= drn_d;
      clr_q   <= clr_d;
      ofm_q   <= ofm_d;
      rdy_q   <= rdy_d;
      ack4_q  <= ack4_d;
      ack5_q  <= ack5_d;
      en4_q   <= en4_d;
      en5_q   <= en5_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ifm_ready         = rdy_q;
  assign bus.fire4_expand_1_en = en4_q;
  assign bus.fire5_expand_1_en = en5_q;
  assign bus.rom_addr          = k_q;
  assign bus.mac_clr           = clr_q;
  assign bus.ofm_sample        = ofm_q;
  assign bus.pixel_idx         = pix_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
endmodule

// File: doc/fire_expand1_scheduler.md
Name: fire_expand1_scheduler

Overview:
- Sequencing controller for the shared fire4/fire5 expand-1x1 MAC array.
- On `start`, it runs layer fire4 and then layer fire5 back to back:
  - drives the per-layer enables;
  - steps the weight ROM address;
  - inserts the MAC clear/bias slot at the end of every output pixel;
  - emits output-sample strobes;
  - waits for the output-RAM writeback acknowledge before switching layers.
- It replaces the free-running timers and sticky feedback registers currently embedded in the datapath with one explicit FSM.

Parameters:
- WOUT, 32, output feature-map width/height; pixels per layer = WOUT*WOUT.
- CHIN, 32, input channels accumulated per output pixel.
- KERNEL_DIM, 1, kernel side; accumulate length N = KERNEL_DIM*KERNEL_DIM*CHIN.
- PIPE_LAT, 2, cycles from the last mac_clr until the final ofm_sample is safe to write (drain length).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run fire4 then fire5
- ifm_valid  in  1  current ifm word (ifm_4/ifm_5) valid
- ifm_ready  out  1  scheduler consumes ifm this cycle
- ram_ack_4  in  1  output RAM finished storing fire4 results
- ram_ack_5  in  1  output RAM finished storing fire5 results
- fire4_expand_1_en  out  1  layer-4 select/enable to datapath
- fire5_expand_1_en  out  1  layer-5 select/enable to datapath
- rom_addr  out  $clog2(N)  weight ROM address (min width 1)
- mac_clr  out  1  end-of-pixel clear/bias slot strobe
- ofm_sample  out  1  output word valid, = mac_clr delayed 1 cycle
- pixel_idx  out  $clog2(WOUT*WOUT)  index of pixel being accumulated
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on completion of fire5

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, counters 0, ack flags 0.
- States: IDLE, RUN4, DRAIN4, WAIT4, RUN5, DRAIN5, WAIT5, DONE.
- Layer enables:
  - fire4_expand_1_en = 1 in RUN4/DRAIN4/WAIT4.
  - fire5_expand_1_en = 1 in RUN5/DRAIN5/WAIT5.
  - The two enables are never both high.
- IDLE:
  - start=1 -> RUN4 next cycle, with rom_addr=0, pixel_idx=0, k=0.
  - start is ignored whenever busy=1.
- RUN sub-phases:
  - ACC: ifm_ready=1 and mac_clr=0. On ifm_valid: k++ and rom_addr=k+1. When k==N-1 is consumed, the next cycle is the CLR slot.
  - ifm_valid=0: everything holds (stall); no clr is generated.
  - CLR slot (exactly one cycle): mac_clr=1, ifm_ready=0, rom_addr=0, k=0.
  - Following the CLR slot:
    - if pixel_idx==WOUT*WOUT-1 -> DRAIN;
    - else pixel_idx++ and ACC resumes.
  - Unstalled pixel cost: N+1 cycles. Unstalled layer cost: WOUT*WOUT*(N+1) cycles.
- ofm_sample:
  - Equals mac_clr registered by one cycle.
  - The DRAIN entry cycle therefore still carries the last ofm_sample.
- DRAIN: hold for PIPE_LAT cycles (ifm_ready=0, no clr), then go to WAIT.
- Ack flags:
  - ram_ack_4/ram_ack_5 set sticky flags ack4/ack5 in any non-IDLE state.
  - Each flag is cleared on entry to its own RUN state.
- WAIT4: leave when ack4 (or ram_ack_4 this cycle); go to RUN5 with counters zeroed.
- WAIT5: leave under the same rule -> DONE.
  - An ack received earlier than WAIT is honoured and causes a 1-cycle WAIT.
- DONE: done=1 for one cycle, then IDLE; busy falls in the same cycle as DONE exits.
- Simultaneous ram_ack_4 and ram_ack_5: both flags set. In RUN4, ack5 is discarded on entry to RUN5.
- rst=1 in any state: next cycle IDLE with all reset values; any in-flight pixel is abandoned and no mac_clr is produced.
- Counter widths: k wraps only via the CLR slot; pixel_idx never exceeds WOUT*WOUT-1.

Test Plan (WOUT=2, CHIN=4, KERNEL_DIM=1, PIPE_LAT=2):
- Nominal run:
  - Stimulus: start pulse, ifm_valid=1 constant, ram_ack_4 asserted 3 cycles after DRAIN4, then ram_ack_5 likewise.
  - Response: rom_addr sequence 0,1,2,3,0 with mac_clr on each 0-after-3; 4 mac_clr per layer; layer phase = 20 cycles; ofm_sample 1 cycle after each mac_clr; exactly one done pulse; enables never overlap.
- Stall:
  - Stimulus: ifm_valid low for 3 cycles when rom_addr=2 in pixel 1.
  - Response: rom_addr/pixel_idx held; no mac_clr during the stall; the layer takes 23 cycles.
- Early ack:
  - Stimulus: ram_ack_4 pulsed during RUN4, pixel 2.
  - Response: WAIT4 lasts 1 cycle; RUN5 starts with rom_addr=0, pixel_idx=0.
- Reset mid-run:
  - Stimulus: rst at RUN5, pixel 1, k=2.
  - Response: next cycle busy=0, both enables 0, rom_addr=0, no mac_clr/done; a subsequent start reruns from fire4.
- Start while busy and late ack:
  - Stimulus: start pulsed in RUN4 and WAIT5; ram_ack_5 withheld 50 cycles.
  - Response: start pulses ignored; state stays WAIT5 with fire5_expand_1_en=1 for 50 cycles; then DONE.
